wb_write_arbiter: RTL and testbench

- Sits after the two MEM/WB pipeline registers of the 2-way core.
- Merges both lanes' writeback requests onto the register file's single write port.
- Performs the per-lane WB data select (ALU / load / JAL link), queues pending writes in order, and stalls the pipeline when the queue cannot absorb a full issue pair.
- Provides two pending-write lookup ports so decode/forwarding sees values not yet in the register file.

---
 rtl/wb_write_arbiter_pkg.sv | 14 +
 rtl/wb_write_arbiter_data_select.sv | 31 +++
 rtl/wb_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: register constants,
// the pending-write entry layout and the default JAL link offset.
package wb_write_arbiter_pkg;

   localparam logic [4:0]  REG_ZERO        = 5'd0;
   localparam logic [4:0]  REG_RA          = 5'd31;
   localparam logic [31:0] LINK_OFFSET_DEF = 32'd8;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_data_select.sv
// Per-lane writeback data mux (JAL link > load > ALU) and request qualification.
// Writes to $0 are never valid.
module wb_data_select
   import wb_write_arbiter_pkg::*;
#(
   parameter logic [31:0] LINK_OFFSET = LINK_OFFSET_DEF
)(
   input  logic        regwrite,
   input  logic [4:0]  dest,
   input  logic [31:0] alu,
   input  logic [31:0] rdata,
   input  logic [31:0] pc,
   input  logic        jal,
   input  logic        memtoreg,
   output logic        valid,
   output wb_entry_t   ent
);

   always_comb begin
      ent.rd = dest;
      if (jal)
         ent.data = pc + LINK_OFFSET;
      else if (memtoreg)
         ent.data = rdata;
      else
         ent.data = alu;
   end

   assign valid = regwrite && (dest != REG_ZERO);

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges two writeback lanes onto one register-file write port through an
// in-order pending queue, with stall and two pending-write lookup ports.
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int          DEPTH       = 4,
   parameter logic [31:0] LINK_OFFSET = LINK_OFFSET_DEF
)(
   input  logic        clk,
   input  logic        Reset,
   input  logic        wb0_regwrite,
   input  logic [4:0]  wb0_reg,
   input  logic [31:0] wb0_alu,
   input  logic [31:0] wb0_rdata,
   input  logic [31:0] wb0_pc,
   input  logic        wb0_jal,
   input  logic        wb0_memtoreg,
   input  logic        wb1_regwrite,
   input  logic [4:0]  wb1_reg,
   input  logic [31:0] wb1_alu,
   input  logic [31:0] wb1_rdata,
   input  logic [31:0] wb1_pc,
   input  logic        wb1_jal,
   input  logic        wb1_memtoreg,
   output logic        stall,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   input  logic [4:0]  lka_reg,
   input  logic [4:0]  lkb_reg,
   output logic        lka_hit,
   output logic        lkb_hit,
   output logic [31:0] lka_data,
   output logic [31:0] lkb_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   wb_entry_t     q [DEPTH];
   logic [AW-1:0] head, tail;
   logic [CW-1:0] count;

   logic          v0, v1, take0, take1, pop, out_we;
   wb_entry_t     e0, e1, first, out_e, push_a, push_b;
   logic [1:0]    n_in, push_n;

   wb_data_select #(.LINK_OFFSET(LINK_OFFSET)) u_sel0 (
      .regwrite(wb0_regwrite), .dest(wb0_reg), .alu(wb0_alu), .rdata(wb0_rdata),
      .pc(wb0_pc), .jal(wb0_jal), .memtoreg(wb0_memtoreg), .valid(v0), .ent(e0)
   );

   wb_data_select #(.LINK_OFFSET(LINK_OFFSET)) u_sel1 (
      .regwrite(wb1_regwrite), .dest(wb1_reg), .alu(wb1_alu), .rdata(wb1_rdata),
      .pc(wb1_pc), .jal(wb1_jal), .memtoreg(wb1_memtoreg), .valid(v1), .ent(e1)
   );

   assign stall = (count == FULL);

   // With an empty queue the oldest incoming write goes straight to the
   // output register, which is equivalent to push-then-pop in one cycle.
   always_comb begin
      take0  = v0 && !(v1 && (e0.rd == e1.rd)) && !stall;
      take1  = v1 && !stall;
      first  = take0 ? e0 : e1;
      n_in   = {1'b0, take0} + {1'b0, take1};
      pop    = (count != '0);
      out_we = 1'b0;
      out_e  = q[head];
      push_n = '0;
      push_a = first;
      push_b = e1;
      if (pop) begin
         out_we = 1'b1;
         push_n = n_in;
      end else if (n_in != 2'd0) begin
         out_we = 1'b1;
         out_e  = first;
         push_n = n_in - 2'd1;
         push_a = e1;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         count    <= '0;
         head     <= '0;
         tail     <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= out_we;
         if (out_we) begin
            rf_waddr <= out_e.rd;
            rf_wdata <= out_e.data;
         end
         head  <= head + AW'(pop);
         tail  <= tail + AW'(push_n);
         count <= count + CW'(push_n) - CW'(pop);
      end
   end

   // Queue storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) q[tail] <= push_a;
      if (push_n == 2'd2) q[tail + AW'(1)] <= push_b;
   end

   logic [1:0][4:0]  lk_reg;
   logic [1:0]       lk_hit;
   logic [1:0][31:0] lk_data;

   assign lk_reg = {lkb_reg, lka_reg};

   // Scan oldest to youngest so the youngest match overwrites earlier ones.
   always_comb begin
      lk_hit  = '0;
      lk_data = '0;
      for (int p = 0; p < 2; p++) begin
         if (lk_reg[p] != REG_ZERO) begin
            if (rf_we && (rf_waddr == lk_reg[p])) begin
               lk_hit[p]  = 1'b1;
               lk_data[p] = rf_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
               if ((CW'(i) < count) && (q[head + AW'(i)].rd == lk_reg[p])) begin
                  lk_hit[p]  = 1'b1;
                  lk_data[p] = q[head + AW'(i)].data;
               end
            end
         end
      end
   end

   assign lka_hit  = lk_hit[0];
   assign lkb_hit  = lk_hit[1];
   assign lka_data = lk_data[0];
   assign lkb_data = lk_data[1];

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus a
// randomized stream checked against a queue-based pending-write model.
module tb_wb_write_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        Reset;
   logic        wb0_regwrite, wb0_jal, wb0_memtoreg;
   logic [4:0]  wb0_reg;
   logic [31:0] wb0_alu, wb0_rdata, wb0_pc;
   logic        wb1_regwrite, wb1_jal, wb1_memtoreg;
   logic [4:0]  wb1_reg;
   logic [31:0] wb1_alu, wb1_rdata, wb1_pc;
   logic        stall, rf_we, lka_hit, lkb_hit;
   logic [4:0]  rf_waddr, lka_reg, lkb_reg;
   logic [31:0] rf_wdata, lka_data, lkb_data;

   int checks = 0;
   int errors = 0;

   wb_write_arbiter #(.DEPTH(DEPTH), .LINK_OFFSET(32'd8)) dut (
      .clk(clk), .Reset(Reset),
      .wb0_regwrite(wb0_regwrite), .wb0_reg(wb0_reg), .wb0_alu(wb0_alu),
      .wb0_rdata(wb0_rdata), .wb0_pc(wb0_pc), .wb0_jal(wb0_jal), .wb0_memtoreg(wb0_memtoreg),
      .wb1_regwrite(wb1_regwrite), .wb1_reg(wb1_reg), .wb1_alu(wb1_alu),
      .wb1_rdata(wb1_rdata), .wb1_pc(wb1_pc), .wb1_jal(wb1_jal), .wb1_memtoreg(wb1_memtoreg),
      .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .lka_reg(lka_reg), .lkb_reg(lkb_reg), .lka_hit(lka_hit), .lkb_hit(lkb_hit),
      .lka_data(lka_data), .lkb_data(lkb_data)
   );

   always #5 clk = ~clk;

   // Reference model: list of accepted-but-unwritten writes plus the output register.
   typedef struct packed { logic [4:0] r; logic [31:0] d; } wr_t;
   wr_t         pend[$];
   logic        m_we;
   logic [4:0]  m_reg;
   logic [31:0] m_data;

   function automatic logic [31:0] lane_val(input logic jal, input logic mtr,
                                            input logic [31:0] pc, input logic [31:0] rdata,
                                            input logic [31:0] alu);
      if (jal) return pc + 32'd8;
      if (mtr) return rdata;
      return alu;
   endfunction

   task automatic model_clear();
      pend.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0;
   endtask

   // Accept this cycle's lanes (unless full), then retire the oldest pending write.
   task automatic model_step();
      bit v0, v1;
      wr_t w;
      if (Reset) begin
         model_clear();
         return;
      end
      if (pend.size() != DEPTH) begin
         v0 = wb0_regwrite && (wb0_reg != 5'd0);
         v1 = wb1_regwrite && (wb1_reg != 5'd0);
         if (v0 && v1 && (wb0_reg == wb1_reg)) v0 = 1'b0;
         if (v0) begin
            w.r = wb0_reg; w.d = lane_val(wb0_jal, wb0_memtoreg, wb0_pc, wb0_rdata, wb0_alu);
            pend.push_back(w);
         end
         if (v1) begin
            w.r = wb1_reg; w.d = lane_val(wb1_jal, wb1_memtoreg, wb1_pc, wb1_rdata, wb1_alu);
            pend.push_back(w);
         end
      end
      if (pend.size() > 0) begin
         w = pend.pop_front();
         m_we = 1'b1; m_reg = w.r; m_data = w.d;
      end else begin
         m_we = 1'b0;
      end
   endtask

   function automatic void m_look(input logic [4:0] r, output logic h, output logic [31:0] d);
      h = 1'b0; d = '0;
      if (r == 5'd0) return;
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].r == r) begin
            h = 1'b1; d = pend[i].d;
            return;
         end
      end
      if (m_we && (m_reg == r)) begin
         h = 1'b1; d = m_data;
      end
   endfunction

   task automatic clear_inputs();
      wb0_regwrite = 0; wb0_reg = 0; wb0_alu = 0; wb0_rdata = 0; wb0_pc = 0; wb0_jal = 0; wb0_memtoreg = 0;
      wb1_regwrite = 0; wb1_reg = 0; wb1_alu = 0; wb1_rdata = 0; wb1_pc = 0; wb1_jal = 0; wb1_memtoreg = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: we=%0b addr=%0d data=%h stall=%0b, want 0 0 0 0", rf_we, rf_waddr, rf_wdata, stall);
      end
      lka_reg = 5'd5; #1;
      checks++;
      if (lka_hit !== 1'b0 || lka_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_lookup: hit=%0b data=%h, want 0 0", lka_hit, lka_data);
      end
      @(negedge clk);
      Reset = 1'b0;
      model_clear();
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      clear_inputs();
      wb0_regwrite = 1; wb0_reg = 5'd5; wb0_alu = 32'h1234; lka_reg = 5'd5;
      tick();
      clear_inputs();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL single_write: we=%0b addr=%0d data=%h, want 1 5 00001234", rf_we, rf_waddr, rf_wdata);
      end
      checks++;
      if (lka_hit !== 1'b1 || lka_data !== 32'h1234) begin
         errors++;
         $display("FAIL single_lookup: hit=%0b data=%h, want 1 00001234", lka_hit, lka_data);
      end
      tick();
      checks++;
      if (rf_we !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: we=%0b, want 0", rf_we);
      end
   endtask

   task automatic test_pair();
      clear_inputs();
      wb0_regwrite = 1; wb0_reg = 5'd3; wb0_memtoreg = 1; wb0_rdata = 32'hAAAA_0000; wb0_alu = 32'hDEAD;
      wb1_regwrite = 1; wb1_reg = 5'd4; wb1_jal = 1; wb1_memtoreg = 1; wb1_pc = 32'h0040_0010;
      wb1_rdata = 32'hBEEF; wb1_alu = 32'hCAFE;
      tick();
      clear_inputs();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA_0000) begin
         errors++;
         $display("FAIL pair_first: we=%0b addr=%0d data=%h, want 1 3 aaaa0000", rf_we, rf_waddr, rf_wdata);
      end
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h0040_0018) begin
         errors++;
         $display("FAIL pair_second: we=%0b addr=%0d data=%h, want 1 4 00400018", rf_we, rf_waddr, rf_wdata);
      end
      tick();
      checks++;
      if (rf_we !== 1'b0) begin
         errors++;
         $display("FAIL pair_idle: we=%0b, want 0", rf_we);
      end
   endtask

   task automatic test_conflict();
      int writes = 0;
      clear_inputs();
      wb0_regwrite = 1; wb0_reg = 5'd7; wb0_alu = 32'h11;
      wb1_regwrite = 1; wb1_reg = 5'd7; wb1_alu = 32'h22;
      lka_reg = 5'd7;
      tick();
      clear_inputs();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22 || lka_data !== 32'h22) begin
         errors++;
         $display("FAIL conflict_write: we=%0b addr=%0d data=%h look=%h, want 1 7 00000022 00000022",
                  rf_we, rf_waddr, rf_wdata, lka_data);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (rf_we === 1'b1) writes++;
      end
      checks++;
      if (writes !== 0) begin
         errors++;
         $display("FAIL conflict_extra: %0d extra writes, want 0", writes);
      end
   endtask

   task automatic test_zero();
      int bad = 0;
      clear_inputs();
      wb0_regwrite = 1; wb0_reg = 5'd0; wb0_alu = 32'h55;
      wb1_regwrite = 1; wb1_reg = 5'd0; wb1_alu = 32'h66;
      lka_reg = 5'd0; lkb_reg = 5'd0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (rf_we !== 1'b0 || lka_hit !== 1'b0 || lkb_hit !== 1'b0) bad++;
      end
      clear_inputs();
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL zero_reg: %0d cycles with a write or hit, want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int  writes = 0, exp_writes = 0;
      bit  seen = 0;
      clear_inputs();
      for (int c = 0; c < 24; c++) begin
         if (c >= 16) clear_inputs();
         else if (!stall) begin
            wb0_regwrite = 1; wb0_reg = 5'($urandom_range(1, 15)); wb0_alu = $urandom;
            wb1_regwrite = 1; wb1_reg = 5'($urandom_range(16, 31)); wb1_alu = $urandom;
         end
         tick();
         if (m_we) exp_writes++;
         if (rf_we === 1'b1) writes++;
         if (stall === 1'b1) seen = 1;
         checks++;
         if (stall !== (pend.size() == DEPTH)) begin
            errors++;
            $display("FAIL b2b_stall c%0d: stall=%0b, want %0b", c, stall, pend.size() == DEPTH);
         end
         checks++;
         if (rf_we !== m_we || (m_we && (rf_waddr !== m_reg || rf_wdata !== m_data))) begin
            errors++;
            $display("FAIL b2b_write c%0d: we=%0b addr=%0d data=%h, want %0b %0d %h",
                     c, rf_we, rf_waddr, rf_wdata, m_we, m_reg, m_data);
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL b2b_stall_seen: stall=0 throughout, want a stall");
      end
      checks++;
      if (writes !== exp_writes) begin
         errors++;
         $display("FAIL b2b_count: %0d writes, want %0d", writes, exp_writes);
      end
   endtask

   task automatic test_lookup_reset();
      int bad = 0;
      clear_inputs();
      wb0_regwrite = 1; wb0_reg = 5'd9;  wb0_alu = 32'h1;
      wb1_regwrite = 1; wb1_reg = 5'd10; wb1_alu = 32'h10;
      tick();
      wb0_reg = 5'd11; wb0_alu = 32'h11;
      wb1_reg = 5'd9;  wb1_alu = 32'h2;
      lka_reg = 5'd9; lkb_reg = 5'd11;
      tick();
      clear_inputs();
      checks++;
      if (lka_hit !== 1'b1 || lka_data !== 32'h2) begin
         errors++;
         $display("FAIL lookup_youngest: hit=%0b data=%h, want 1 00000002", lka_hit, lka_data);
      end
      checks++;
      if (lkb_hit !== 1'b1 || lkb_data !== 32'h11) begin
         errors++;
         $display("FAIL lookup_queue: hit=%0b data=%h, want 1 00000011", lkb_hit, lkb_data);
      end
      lkb_reg = 5'd10; #1;
      checks++;
      if (lkb_hit !== 1'b1 || lkb_data !== 32'h10 || rf_we !== 1'b1) begin
         errors++;
         $display("FAIL lookup_outreg: hit=%0b data=%h we=%0b, want 1 00000010 1", lkb_hit, lkb_data, rf_we);
      end
      #1 Reset = 1'b1;
      #1;
      model_clear();
      checks++;
      if (rf_we !== 1'b0 || lka_hit !== 1'b0 || lkb_hit !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: we=%0b hita=%0b hitb=%0b stall=%0b, want 0 0 0 0",
                  rf_we, lka_hit, lkb_hit, stall);
      end
      @(negedge clk);
      Reset = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (rf_we !== 1'b0 || lka_hit !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_flush: %0d cycles with stale write or hit, want 0", bad);
      end
   endtask

   task automatic test_random();
      logic        eh;
      logic [31:0] ed;
      for (int c = 0; c < 320; c++) begin
         if (c >= 300) clear_inputs();
         else begin
            wb0_regwrite = ($urandom_range(0, 99) < 85); wb0_reg = 5'($urandom_range(0, 7));
            wb0_alu = $urandom; wb0_rdata = $urandom; wb0_pc = $urandom;
            wb0_jal = ($urandom_range(0, 3) == 0); wb0_memtoreg = 1'($urandom_range(0, 1));
            wb1_regwrite = ($urandom_range(0, 99) < 85); wb1_reg = 5'($urandom_range(0, 7));
            wb1_alu = $urandom; wb1_rdata = $urandom; wb1_pc = $urandom;
            wb1_jal = ($urandom_range(0, 3) == 0); wb1_memtoreg = 1'($urandom_range(0, 1));
         end
         lka_reg = 5'($urandom_range(0, 7));
         lkb_reg = 5'($urandom_range(0, 7));
         tick();
         checks++;
         if (stall !== (pend.size() == DEPTH)) begin
            errors++;
            $display("FAIL rnd_stall c%0d: stall=%0b, want %0b", c, stall, pend.size() == DEPTH);
         end
         checks++;
         if (rf_we !== m_we || (m_we && (rf_waddr !== m_reg || rf_wdata !== m_data))) begin
            errors++;
            $display("FAIL rnd_write c%0d: we=%0b addr=%0d data=%h, want %0b %0d %h",
                     c, rf_we, rf_waddr, rf_wdata, m_we, m_reg, m_data);
         end
         m_look(lka_reg, eh, ed);
         checks++;
         if (lka_hit !== eh || lka_data !== ed) begin
            errors++;
            $display("FAIL rnd_lka c%0d reg %0d: hit=%0b data=%h, want %0b %h", c, lka_reg, lka_hit, lka_data, eh, ed);
         end
         m_look(lkb_reg, eh, ed);
         checks++;
         if (lkb_hit !== eh || lkb_data !== ed) begin
            errors++;
            $display("FAIL rnd_lkb c%0d reg %0d: hit=%0b data=%h, want %0b %h", c, lkb_reg, lkb_hit, lkb_data, eh, ed);
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      clear_inputs();
      lka_reg = '0;
      lkb_reg = '0;
      model_clear();
      test_reset();
      test_single();
      test_pair();
      test_conflict();
      test_zero();
      test_back_to_back();
      test_lookup_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
